mio_mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's memory/IO bus. Accepts one request at a time from the CPU over `CPU_MIO`, `mem_w`, `Addr_out` and `Data_out`, and serves it from an internal word-addressed RAM. After an optional number of wait states it returns read data on `Data_in` with a one-cycle `MIO_ready` pulse. The block replaces the hard-wired `MIO_ready=1` stub in CPU simulation and on-board builds, so the CPU's wait-on-ready paths are actually exercised.

---
 rtl/mio_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mio_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mio_mem_responder.sv
// -----------------------------------------------------------------------------
// mio_mem_responder
//
// Memory-side responder for the multicycle CPU's memory/IO bus. It takes one
// request at a time, serves it from an internal word-addressed RAM and answers
// with a single-cycle MIO_ready pulse, so the CPU's wait-on-ready paths are
// really exercised instead of being short-circuited by a constant ready.
//
// Optional feature macro: MIO_WAIT_EN
//   defined   : WAIT state, wait counter and WAIT_CYCLES parameter are built in.
//               The response comes WAIT_CYCLES cycles after the request edge.
//   undefined : no WAIT state and no counter, fixed one-cycle response.
//
// Parameters
//   ADDR_W       word-index width, RAM depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states before the response, 0..15 (MIO_WAIT_EN only)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset, priority over every transition
//   CPU_MIO    request valid, sampled only in IDLE
//   mem_w      1 = write, 0 = read
//   Addr_out   CPU byte address; bits [1:0] ignored
//   Data_out   write data
//   Data_in    read data, holds the last read value until the next read
//   MIO_ready  one-cycle access-complete pulse (RESP cycle)
//   addr_err   out-of-range flag, coincident with MIO_ready
//   state      FSM state for debug (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module mio_mem_responder #(
  parameter int ADDR_W = 10
`ifdef MIO_WAIT_EN
  , parameter int WAIT_CYCLES = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        addr_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [2**ADDR_W];

  // Decode of the live bus inputs.
  logic [ADDR_W-1:0] live_idx;
  logic              live_oor;
  assign live_idx = Addr_out[ADDR_W+1:2];
  assign live_oor = |Addr_out[31:ADDR_W+2];

  // Byte offset within the word has no meaning here (no byte enables).
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^Addr_out[1:0];

  // The access selected for the edge that enters RESP.
  logic              acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;
  logic [31:0]       acc_data;
  logic              enter_resp;

`ifdef MIO_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [3:0]        wait_cnt;
  logic              req_we;
  logic [ADDR_W-1:0] req_idx;
  logic              req_oor;
  logic [31:0]       req_data;

  // Request registers hold the access through WAIT; the bus is ignored there.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && CPU_MIO) begin
      req_we   <= mem_w;
      req_idx  <= live_idx;
      req_oor  <= live_oor;
      req_data <= Data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (state_q == IDLE && CPU_MIO) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state_q == WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`endif

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_we   = mem_w;
    acc_idx  = live_idx;
    acc_oor  = live_oor;
    acc_data = Data_out;
`ifdef MIO_WAIT_EN
    if (state_q == WAIT) begin
      acc_we   = req_we;
      acc_idx  = req_idx;
      acc_oor  = req_oor;
      acc_data = req_data;
    end
`endif
    case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
`ifdef MIO_WAIT_EN
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MIO_WAIT_EN
      WAIT: if (wait_cnt == 4'd0) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Zero-wait path takes the live inputs here; they equal what IDLE captures.
    enter_resp = (state_d == RESP);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      MIO_ready <= 1'b0;
      addr_err  <= 1'b0;
      Data_in   <= 32'h0;
    end else begin
      state_q   <= state_d;
      MIO_ready <= enter_resp;
      addr_err  <= enter_resp && acc_oor;
      if (enter_resp && !acc_we) begin
        Data_in <= acc_oor ? 32'h0 : mem[acc_idx];
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would prevent RAM inference.
  // Reset still blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_we && !acc_oor) begin
      mem[acc_idx] <= acc_data;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mio_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mio_mem_responder
//
// Self-checking bench for mio_mem_responder (ADDR_W=10, default WAIT_CYCLES=2).
// Expected latency follows the MIO_WAIT_EN build option. Directed vectors come
// from a table; multi-cycle cases (reset, back-to-back, reset mid-write) are
// hand-written; a random phase is checked against an array model of the RAM.
// -----------------------------------------------------------------------------
module tb_mio_mem_responder;

`ifdef MIO_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        addr_err;
  logic [1:0]  state;

  mio_mem_responder #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .Addr_out  (Addr_out),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .addr_err  (addr_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_din;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] model_mem [16];
  logic [31:0] last_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus access starting at a negedge with the DUT idle. Checks latency,
  // returned data, error flag and that the ready pulse lasts a single cycle.
  task automatic do_access(input string nm, input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_din,
                           input bit exp_err);
    int k;
    CPU_MIO  = 1'b1;
    mem_w    = we;
    Addr_out = addr;
    Data_out = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        CPU_MIO  = 1'b0;
        mem_w    = 1'($urandom);
        Addr_out = $urandom;
        Data_out = $urandom;
      end
    end while (!MIO_ready && k < 40);
    check({nm, "_latency"}, 32'(k), 32'(W + 1));
    check({nm, "_data"}, Data_in, exp_din);
    check({nm, "_err"}, 32'(addr_err), 32'(exp_err));
    @(negedge clk);
    check({nm, "_ready_width"}, 32'(MIO_ready), 32'd0);
  endtask

  // Write 0x12345678 to 0x10 and assert reset at negedge krst after the
  // request edge (0 = on the request edge itself). The write must not land.
  task automatic reset_write(input int krst);
    string nm;
    nm = $sformatf("rstwr%0d", krst);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'h10;
    Data_out = 32'h12345678;
    if (krst == 0) reset = 1'b1;
    for (int k = 1; k <= krst; k++) begin
      @(negedge clk);
      if (k == 1) begin
        CPU_MIO = 1'b0;
        check({nm, "_wait_state"}, 32'(state), 32'd1);
      end
      check({nm, "_no_ready"}, 32'(MIO_ready), 32'd0);
      if (k == krst) reset = 1'b1;
    end
    @(negedge clk);
    CPU_MIO = 1'b0;
    check({nm, "_ready_in_reset"}, 32'(MIO_ready), 32'd0);
    check({nm, "_state_in_reset"}, 32'(state), 32'd0);
    check({nm, "_din_in_reset"}, Data_in, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check({nm, "_ready_after"}, 32'(MIO_ready), 32'd0);
    last_rd = 32'h0;
    do_access({nm, "_readback"}, 1'b0, 32'h10, 32'h0, 32'hCAFE0010, 1'b0);
    last_rd = 32'hCAFE0010;
  endtask

  initial begin
    int          pk [2];
    logic [31:0] pd [2];
    int          p;

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h23ff0004, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,        32'h23ff0004, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,        32'h0,        1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h00000020, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0004, 32'h03e00008, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,        32'h00000020, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,        32'h03e00008, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_000B, 32'h0,        32'h23ff0004, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'hCAFE0010, 32'h23ff0004, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,        32'hCAFE0010, 1'b0};

    // Reset held for three cycles with a request pending.
    reset    = 1'b1;
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_out = 32'h8;
    Data_out = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d_ready", i), 32'(MIO_ready), 32'd0);
      check($sformatf("reset%0d_din", i), Data_in, 32'h0);
      check($sformatf("reset%0d_state", i), 32'(state), 32'd0);
      check($sformatf("reset%0d_err", i), 32'(addr_err), 32'd0);
    end
    CPU_MIO = 1'b0;
    reset   = 1'b0;
    @(negedge clk);

    // Directed table.
    last_rd = 32'h0;
    for (int i = 0; i < 12; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                vecs[i].exp_din, vecs[i].exp_err);
      if (!vecs[i].we) last_rd = vecs[i].exp_din;
    end

    // Back-to-back reads with CPU_MIO held high; the address switches to 0x4
    // right after the first request edge, which must not affect that read.
    CPU_MIO  = 1'b1;
    mem_w    = 1'b0;
    Addr_out = 32'h0;
    p = 0;
    pk[0] = 0; pk[1] = 0;
    pd[0] = 32'h0; pd[1] = 32'h0;
    for (int k = 1; k <= 60 && p < 2; k++) begin
      @(negedge clk);
      if (k == 1) Addr_out = 32'h4;
      if (MIO_ready) begin
        pk[p] = k;
        pd[p] = Data_in;
        p++;
        if (p == 2) CPU_MIO = 1'b0;
      end
    end
    CPU_MIO = 1'b0;
    check("b2b_pulses", 32'(p), 32'd2);
    check("b2b_first_latency", 32'(pk[0]), 32'(W + 1));
    check("b2b_spacing", 32'(pk[1] - pk[0]), 32'(W + 2));
    check("b2b_data0", pd[0], 32'h00000020);
    check("b2b_data1", pd[1], 32'h03e00008);
    @(negedge clk);
    check("b2b_ready_low", 32'(MIO_ready), 32'd0);
    check("b2b_idle", 32'(state), 32'd0);
    last_rd = 32'h03e00008;

    // Reset during WAIT and on the edge that would enter RESP.
    for (int kr = 0; kr <= W; kr++) reset_write(kr);

    // Random phase against an array model covering word indices 0..15.
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      do_access($sformatf("init%0d", i), 1'b1, 32'(i * 4), model_mem[i], last_rd, 1'b0);
    end
    for (int n = 0; n < 120; n++) begin
      bit          we, oor;
      int          idx;
      logic [31:0] addr, data, exp;
      we   = 1'($urandom_range(0, 1));
      oor  = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 15);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      if (oor) addr = addr | (32'($urandom_range(1, 20'hFFFFF)) << 12);
      data = $urandom;
      if (!we) begin
        exp     = oor ? 32'h0 : model_mem[idx];
        last_rd = exp;
      end else begin
        exp = last_rd;
      end
      do_access($sformatf("rnd%0d", n), we, addr, data, exp, oor);
      if (we && !oor) model_mem[idx] = data;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
